// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
// Holds the ratio width, the controller state type and the reset ratio.
`timescale 1ns/1ps
package clk_div_pkg;

   localparam int unsigned RATIO_W = 8;
   localparam logic [RATIO_W-1:0] DEF_RATIO = 8'd2;

   typedef logic [RATIO_W-1:0] ratio_t;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } state_t;

   // A programmed ratio of zero divides like a ratio of one.
   function automatic ratio_t eff_ratio(input ratio_t r);
      return (r == '0) ? ratio_t'(1) : r;
   endfunction

endpackage

// File: rtl/clk_div_core.sv
// Divider datapath: half-period counter, registered clk_out/tick and the
// ratio currently in effect, reloaded only on the controller's load strobe.
`timescale 1ns/1ps
module clk_div_core #(
   parameter clk_div_pkg::ratio_t RST_RATIO = clk_div_pkg::DEF_RATIO
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                load_i,
   input  clk_div_pkg::ratio_t ratio_i,
   output logic                clk_out_o,
   output logic                tick_o,
   output logic                wrap_o,
   output clk_div_pkg::ratio_t cur_ratio_o
);
   import clk_div_pkg::*;

   ratio_t cnt_q, cnt_d;
   ratio_t ratio_q;
   ratio_t eff;
   logic   clk_out_q;
   logic   tick_q;
   logic   wrap;

   assign eff  = eff_ratio(ratio_q);
   assign wrap = (cnt_q == eff - ratio_t'(1));

   always_comb begin
      cnt_d = wrap ? '0 : cnt_q + ratio_t'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the edge, independent of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q     <= '0;
         clk_out_q <= 1'b0;
         tick_q    <= 1'b0;
         ratio_q   <= RST_RATIO;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= wrap;
         if (wrap) begin
            clk_out_q <= ~clk_out_q;
         end
         // The controller only raises load_i on a wrap cycle, so the new
         // ratio governs the half-period that starts after this toggle.
         if (load_i) begin
            ratio_q <= ratio_i;
         end
      end
   end

   assign clk_out_o   = clk_out_q;
   assign tick_o      = tick_q;
   assign wrap_o      = wrap;
   assign cur_ratio_o = ratio_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock divider with two round-robin arbitrated ratio-change requesters;
// an accepted ratio is committed only at a clk_out toggle boundary.
`timescale 1ns/1ps
module clk_div_ctrl #(
   parameter clk_div_pkg::ratio_t DEF_RATIO = clk_div_pkg::DEF_RATIO
) (
   input  logic                clk_in,
   input  logic                rst_n,
   input  logic [1:0]          req,
   input  clk_div_pkg::ratio_t ratio0,
   input  clk_div_pkg::ratio_t ratio1,
   output logic [1:0]          gnt,
   output logic                busy,
   output logic                clk_out,
   output logic                tick,
   output clk_div_pkg::ratio_t cur_ratio
);
   import clk_div_pkg::*;

   state_t     state_q;
   ratio_t     pend_ratio_q;
   logic       sel_q;
   logic       last_q;
   logic [1:0] gnt_q;
   logic       busy_q;
   logic       wrap;
   logic       commit;
   logic       pick;

   // With both requesting, serve the one not granted last; otherwise the only one.
   assign pick   = (req == 2'b11) ? ~last_q : req[1];
   assign commit = (state_q == PEND) && wrap;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         pend_ratio_q <= '0;
         sel_q        <= 1'b0;
         last_q       <= 1'b1;
         gnt_q        <= 2'b00;
         busy_q       <= 1'b0;
      end else begin
         gnt_q <= 2'b00;
         case (state_q)
            IDLE: begin
               // A requester still holding req during its gnt cycle is ignored.
               if ((req != 2'b00) && (gnt_q == 2'b00)) begin
                  state_q      <= PEND;
                  sel_q        <= pick;
                  pend_ratio_q <= pick ? ratio1 : ratio0;
                  busy_q       <= 1'b1;
               end
            end
            PEND: begin
               if (wrap) begin
                  state_q <= IDLE;
                  gnt_q   <= sel_q ? 2'b10 : 2'b01;
                  busy_q  <= 1'b0;
                  last_q  <= sel_q;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   clk_div_core #(
      .RST_RATIO(DEF_RATIO)
   ) u_core (
      .clk_i      (clk_in),
      .rst_ni     (rst_n),
      .load_i     (commit),
      .ratio_i    (pend_ratio_q),
      .clk_out_o  (clk_out),
      .tick_o     (tick),
      .wrap_o     (wrap),
      .cur_ratio_o(cur_ratio)
   );

   assign gnt  = gnt_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: request vectors with a grant
// scoreboard, plus directed sequences for reset and arbitration corners.
`timescale 1ns/1ps
module tb_clk_div_ctrl;
   import clk_div_pkg::*;

   logic       clk_in = 1'b0;
   logic       rst_n  = 1'b0;
   logic [1:0] req    = 2'b00;
   ratio_t     ratio0 = '0;
   ratio_t     ratio1 = '0;
   logic [1:0] gnt;
   logic       busy;
   logic       clk_out;
   logic       tick;
   ratio_t     cur_ratio;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [1:0] g;
      ratio_t     r;
   } exp_t;

   typedef struct {
      logic [1:0] req;
      ratio_t     r0;
      ratio_t     r1;
      int         n_exp;
      logic [1:0] g0;
      ratio_t     e0;
      logic [1:0] g1;
      ratio_t     e1;
      int         hp;
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[6];

   clk_div_ctrl #(
      .DEF_RATIO(8'd2)
   ) dut (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .req      (req),
      .ratio0   (ratio0),
      .ratio1   (ratio1),
      .gnt      (gnt),
      .busy     (busy),
      .clk_out  (clk_out),
      .tick     (tick),
      .cur_ratio(cur_ratio)
   );

   always #25 clk_in = ~clk_in;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_clk_out"}, clk_out, 0);
      check({tag, "_tick"}, tick, 0);
      check({tag, "_gnt"}, gnt, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_cur_ratio"}, cur_ratio, 2);
   endtask

   task automatic do_reset();
      @(negedge clk_in);
      rst_n = 1'b0;
      req   = 2'b00;
      #1;
      check_reset_outputs("rst");
      @(negedge clk_in);
      rst_n = 1'b1;
   endtask

   // Cycles from the current negedge to the next negedge showing tick.
   task automatic measure_gap(output int gap);
      logic start_clk;
      logic toggled;
      start_clk = clk_out;
      toggled   = ~start_clk;
      gap = 0;
      do begin
         @(negedge clk_in);
         gap++;
      end while (!tick && gap < 300);
      check("clk_out_toggled_with_tick", clk_out, toggled);
   endtask

   task automatic wait_gnt(input string name);
      int t;
      t = 0;
      do begin
         @(negedge clk_in);
         t++;
      end while (gnt == 2'b00 && t < 300);
      if (gnt == 2'b00) check({name, "_timeout"}, 0, 1);
   endtask

   // Pops one expectation per grant; requesters drop req on seeing their gnt.
   task automatic run_sb();
      exp_t e;
      int   t;
      t = 0;
      while (exp_q.size() != 0 && t < 400) begin
         @(negedge clk_in);
         t++;
         if (gnt != 2'b00) begin
            e = exp_q.pop_front();
            check("sb_gnt", gnt, e.g);
            check("sb_cur_ratio", cur_ratio, e.r);
            check("sb_tick_with_gnt", tick, 1);
            check("sb_busy_at_gnt", busy, 0);
            req = req & ~gnt;
         end
      end
      check("sb_drained", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      int   g;
      logic seen_gnt;
      exp_t e;

      vecs[0] = '{req: 2'b01, r0: 8'd5, r1: 8'd0, n_exp: 1, g0: 2'b01, e0: 8'd5, g1: 2'b00, e1: 8'd0, hp: 5};
      vecs[1] = '{req: 2'b10, r0: 8'd0, r1: 8'd3, n_exp: 1, g0: 2'b10, e0: 8'd3, g1: 2'b00, e1: 8'd0, hp: 3};
      vecs[2] = '{req: 2'b11, r0: 8'd3, r1: 8'd4, n_exp: 2, g0: 2'b01, e0: 8'd3, g1: 2'b10, e1: 8'd4, hp: 4};
      vecs[3] = '{req: 2'b10, r0: 8'd9, r1: 8'd0, n_exp: 1, g0: 2'b10, e0: 8'd0, g1: 2'b00, e1: 8'd0, hp: 1};
      vecs[4] = '{req: 2'b01, r0: 8'd1, r1: 8'd6, n_exp: 1, g0: 2'b01, e0: 8'd1, g1: 2'b00, e1: 8'd0, hp: 1};
      vecs[5] = '{req: 2'b11, r0: 8'd7, r1: 8'd2, n_exp: 2, g0: 2'b01, e0: 8'd7, g1: 2'b10, e1: 8'd2, hp: 2};

      // Power-on reset, then default divide-by-2 half-periods.
      repeat (2) @(negedge clk_in);
      check_reset_outputs("por");
      rst_n = 1'b1;
      measure_gap(g);
      check("first_toggle_after_release", g, 2);
      for (int i = 0; i < 3; i++) begin
         measure_gap(g);
         check("default_half_period", g, 2);
      end
      check("default_cur_ratio", cur_ratio, 2);

      // Ratio change requested mid half-period: prior half-period stays 2.
      ratio0 = 8'd5;
      req    = 2'b01;
      @(negedge clk_in);
      check("mid_busy_next_cycle", busy, 1);
      check("mid_no_early_gnt", gnt, 0);
      measure_gap(g);
      check("mid_prior_half_period", g + 1, 2);
      check("mid_gnt", gnt, 2'b01);
      check("mid_cur_ratio", cur_ratio, 5);
      req = 2'b00;
      @(negedge clk_in);
      check("mid_gnt_one_cycle", gnt, 0);
      measure_gap(g);
      check("mid_first_new_half_period", g + 1, 5);
      for (int i = 0; i < 2; i++) begin
         measure_gap(g);
         check("mid_new_half_period", g, 5);
      end

      // Reset while a request is pending discards it.
      do_reset();
      measure_gap(g);
      check("rp_first_toggle", g, 2);
      ratio0 = 8'd8;
      req    = 2'b01;
      @(negedge clk_in);
      check("rp_busy", busy, 1);
      #5;
      rst_n = 1'b0;
      req   = 2'b00;
      #1;
      check_reset_outputs("rp_async");
      @(negedge clk_in);
      rst_n    = 1'b1;
      seen_gnt = 1'b0;
      repeat (30) begin
         @(negedge clk_in);
         if (gnt != 2'b00) seen_gnt = 1'b1;
      end
      check("rp_no_gnt_after_release", seen_gnt, 0);
      check("rp_cur_ratio", cur_ratio, 2);
      check("rp_busy_after", busy, 0);

      // Requester 1 arrives while requester 0 is pending.
      ratio0 = 8'd3;
      req    = 2'b01;
      @(negedge clk_in);
      check("late_busy_r0", busy, 1);
      ratio1 = 8'd6;
      req    = 2'b11;
      wait_gnt("late_gnt0");
      check("late_gnt0", gnt, 2'b01);
      check("late_ratio0", cur_ratio, 3);
      req = 2'b10;
      @(negedge clk_in);
      check("late_not_accepted_in_gnt_cycle", busy, 0);
      @(negedge clk_in);
      check("late_accepted_after_gnt", busy, 1);
      wait_gnt("late_gnt1");
      check("late_gnt1", gnt, 2'b10);
      check("late_ratio1", cur_ratio, 6);
      req = 2'b00;

      // Table-driven request vectors with grant scoreboard.
      foreach (vecs[i]) begin
         do_reset();
         ratio0 = vecs[i].r0;
         ratio1 = vecs[i].r1;
         req    = vecs[i].req;
         e.g = vecs[i].g0;
         e.r = vecs[i].e0;
         exp_q.push_back(e);
         if (vecs[i].n_exp > 1) begin
            e.g = vecs[i].g1;
            e.r = vecs[i].e1;
            exp_q.push_back(e);
         end
         run_sb();
         for (int k = 0; k < 3; k++) begin
            measure_gap(g);
            check("vec_half_period", g, vecs[i].hp);
         end
         check("vec_busy_idle", busy, 0);
         req = 2'b00;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
